// File: rtl/exec_iter_divider.sv
// exec_iter_divider
//   Iterative restoring divider for DIV/DIVU/REM/REMU. Signed operations are
//   computed on operand magnitudes. The result sign is applied on the cycle
//   after the last division step.
//
//   Parameters
//     XLEN            operand/result width (32 or 64)
//     STEPS_PER_CYCLE quotient bits retired per clock (1, 2 or 4; divides XLEN)
//
//   Ports
//     clk        rising-edge clock
//     start      asynchronous active-low reset
//     flush      aborts any operation in flight; wins over ex_fire
//     ex_fire    one-cycle launch pulse; samples op, in_a, in_b
//     op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//     in_a       dividend
//     in_b       divisor
//     busy       high while in CALC
//     div_valid  high while divresult holds a completed result
//     divresult  quotient or remainder, selected by op
//
//   Handshake: ex_fire is a fire-and-forget launch with no ready. It is
//   accepted in every state. A launch during CALC abandons the old operation.
//   div_valid is a level that stays high in DONE until the next ex_fire or
//   flush.
//
//   Optional feature: define DIV_EARLY_OUT_EN to skip leading zero chunks of
//   the dividend magnitude at launch. Results are unchanged; only latency
//   shrinks.
module exec_iter_divider #(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            start,
    input  logic            flush,
    input  logic            ex_fire,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            busy,
    output logic            div_valid,
    output logic [XLEN-1:0] divresult
);
    localparam int N  = XLEN / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;     // dividend bits shifting out, quotient shifting in
    logic [XLEN-1:0] rem_q, rem_d;     // partial remainder (always < divisor between steps)
    logic [XLEN-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [XLEN-1:0] a_q, a_d;         // original dividend, needed for x/0 remainder
    logic [XLEN-1:0] res_q, res_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    // Launch decode
    logic            is_signed;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            in_dz, in_ovf;
    logic [CW-1:0]   launch_cnt;
    logic [XLEN-1:0] launch_quo;

    // Datapath results
    logic [XLEN-1:0] step_quo, step_rem;
    logic [XLEN-1:0] fin_quo, fin_rem;

    always_comb begin
        is_signed = ~op[0];
        neg_a     = is_signed & in_a[XLEN-1];
        neg_b     = is_signed & in_b[XLEN-1];
        mag_a     = neg_a ? -in_a : in_a;
        mag_b     = neg_b ? -in_b : in_b;
        in_dz     = (in_b == '0);
        in_ovf    = is_signed & (in_a == MOST_NEG) & (&in_b);
    end

`ifdef DIV_EARLY_OUT_EN
    // Count significant bits of the dividend magnitude and pre-shift it so the
    // leading zero chunks are never iterated. Those chunks could only have
    // produced zero quotient bits.
    always_comb begin : early_out_count
        int sig_bits;
        int iters;
        sig_bits = 0;
        for (int i = 0; i < XLEN; i++) begin
            if (mag_a[i]) sig_bits = i + 1;
        end
        iters = (sig_bits + STEPS_PER_CYCLE - 1) / STEPS_PER_CYCLE;
        if (iters == 0) iters = 1;
        launch_cnt = CW'(iters);
        launch_quo = mag_a << ((N - iters) * STEPS_PER_CYCLE);
    end
`else
    always_comb begin
        launch_cnt = CW'(N);
        launch_quo = mag_a;
    end
`endif

    // STEPS_PER_CYCLE restoring steps on an XLEN+1-bit trial remainder
    always_comb begin : div_steps
        logic [XLEN:0] trial;
        step_rem = rem_q;
        step_quo = quo_q;
        trial    = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            trial    = {step_rem, step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial       = trial - {1'b0, dvs_q};
                step_quo[0] = 1'b1;
            end
            step_rem = trial[XLEN-1:0];
        end
    end

    // Sign correction and special-case overrides. Negating zero yields zero,
    // so a zero quotient or remainder never picks up a sign.
    always_comb begin
        fin_quo = neg_quo_q ? -quo_q : quo_q;
        fin_rem = neg_rem_q ? -rem_q : rem_q;
        if (dz_q) begin
            fin_quo = '1;
            fin_rem = a_q;
        end
        if (ovf_q) begin
            fin_quo = MOST_NEG;
            fin_rem = '0;
        end
    end

    // Next-state / datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        a_d       = a_q;
        res_d     = res_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;

        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else if (ex_fire) begin
            state_d   = CALC;
            valid_d   = 1'b0;
            // Special cases spend a single dummy iteration, then finalize.
            cnt_d     = (in_dz | in_ovf) ? CW'(1) : launch_cnt;
            quo_d     = launch_quo;
            rem_d     = '0;
            dvs_d     = mag_b;
            a_d       = in_a;
            is_rem_d  = op[1];
            neg_quo_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            dz_d      = in_dz;
            ovf_d     = in_ovf;
        end else if (state_q == CALC) begin
            if (cnt_q != '0) begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
            end else begin
                res_d   = is_rem_q ? fin_rem : fin_quo;
                valid_d = 1'b1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            a_q       <= '0;
            res_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            a_q       <= a_d;
            res_q     <= res_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign div_valid = valid_q;
    assign divresult = res_q;

endmodule

// File: tb/tb_exec_iter_divider.sv
// Directed bench for exec_iter_divider (XLEN=32). Instance dut uses one step
// per cycle; dut2 uses two steps per cycle and shares every input except its
// launch pulse. Expected results come from a behavioural model and are queued
// at launch, then popped when div_valid rises.
module tb_exec_iter_divider;
    logic        clk      = 1'b0;
    logic        start    = 1'b0;
    logic        flush    = 1'b0;
    logic        ex_fire  = 1'b0;
    logic        ex_fire2 = 1'b0;
    logic [1:0]  op       = 2'b00;
    logic [31:0] in_a     = '0;
    logic [31:0] in_b     = '0;
    logic        busy, div_valid, busy2, div_valid2;
    logic [31:0] divresult, divresult2;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res1  = '0;

    always #5 clk = ~clk;

    exec_iter_divider #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .start(start), .flush(flush), .ex_fire(ex_fire), .op(op),
        .in_a(in_a), .in_b(in_b), .busy(busy), .div_valid(div_valid),
        .divresult(divresult)
    );

    exec_iter_divider #(.XLEN(32), .STEPS_PER_CYCLE(2)) dut2 (
        .clk(clk), .start(start), .flush(flush), .ex_fire(ex_fire2), .op(op),
        .in_a(in_a), .in_b(in_b), .busy(busy2), .div_valid(div_valid2),
        .divresult(divresult2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00:   if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return $signed(a) / $signed(b);
            2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            2'b10:   if (b == 0) return a; else if (ovf) return 32'h0; else return $signed(a) % $signed(b);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    // Edges from the launch edge until div_valid is first seen high
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int s);
        logic sgn;
        sgn = ~o[0];
        if (b == 0) return 2;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
        begin
            logic [31:0] mag;
            int sig;
            int it;
            mag = (sgn && a[31]) ? -a : a;
            sig = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) sig = i + 1;
            it = (sig + s - 1) / s;
            if (it == 0) it = 1;
            return it + 1;
        end
`else
        return 32 / s + 1;
`endif
    endfunction

    task automatic launch(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op   = o;
        in_a = a;
        in_b = b;
        if (sel) ex_fire2 = 1'b1;
        else     ex_fire  = 1'b1;
        @(negedge clk);
        ex_fire  = 1'b0;
        ex_fire2 = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, input int budget, output int lat);
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if ((sel ? div_valid2 : div_valid) === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic do_op(input bit sel, input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          elat;
        logic [31:0] e;
        elat = exp_lat(o, a, b, sel ? 2 : 1);
        exp_q.push_back(model(o, a, b));
        launch(sel, o, a, b);
        chk({tag, " busy_after_launch"}, sel ? busy2 : busy, 1'b1);
        chk({tag, " valid_cleared"}, sel ? div_valid2 : div_valid, 1'b0);
        wait_valid(sel, 80, lat);
        chk({tag, " latency"}, lat, elat);
        e = exp_q.pop_front();
        chk({tag, " result"}, sel ? divresult2 : divresult, e);
        if (!sel) last_res1 = e;
    endtask

    task automatic no_valid_window(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (div_valid === 1'b1 || busy === 1'b1) seen++;
        end
        chk({tag, " no_activity"}, seen, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset busy", busy, 1'b0);
        chk("reset valid", div_valid, 1'b0);
        chk("reset result", divresult, 32'h0);
        repeat (2) @(negedge clk);
        start = 1'b1;

        // Basic unsigned
        do_op(0, "divu_100_7", 2'b01, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        chk("done hold valid", div_valid, 1'b1);
        chk("done hold result", divresult, 32'd14);
        do_op(0, "remu_100_7", 2'b11, 32'd100, 32'd7);

        // Signed
        do_op(0, "div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7);
        do_op(0, "rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7);
        do_op(0, "div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9);
        do_op(0, "div_m6_7", 2'b00, 32'hFFFF_FFFA, 32'd7);

        // Special cases
        do_op(0, "divu_5_0", 2'b01, 32'd5, 32'd0);
        do_op(0, "rem_5_0", 2'b10, 32'd5, 32'd0);
        do_op(0, "rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0);
        do_op(0, "div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, "rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, "divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, "div_0_5", 2'b00, 32'd0, 32'd5);
        do_op(0, "divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);

        // Two steps per cycle
        do_op(1, "s2_div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7);
        do_op(1, "s2_remu_big", 2'b11, 32'hDEAD_BEEF, 32'd12345);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            do_op(i[0], $sformatf("rand%0d", i), ro, ra, rb);
        end

        // Flush in DONE
        do_op(0, "pre_flush", 2'b01, 32'd77, 32'd7);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done valid", div_valid, 1'b0);
        chk("flush_done result kept", divresult, last_res1);

        // Flush mid-CALC at the tenth edge after launch
        launch(0, 2'b01, 32'hF000_0000, 32'd3);
        repeat (8) @(negedge clk);
        chk("flush_calc busy before", busy, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_calc busy", busy, 1'b0);
        chk("flush_calc valid", div_valid, 1'b0);
        chk("flush_calc result kept", divresult, last_res1);
        no_valid_window("flush_calc", 40);

        // Flush together with ex_fire
        @(negedge clk);
        op = 2'b01; in_a = 32'd9; in_b = 32'd3;
        flush = 1'b1; ex_fire = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_fire = 1'b0;
        chk("flush_fire busy", busy, 1'b0);
        chk("flush_fire valid", div_valid, 1'b0);
        no_valid_window("flush_fire", 40);

        // ex_fire during CALC restarts; the first result is discarded
        exp_q.push_back(model(2'b01, 32'hFFFF_0000, 32'd7));
        launch(0, 2'b01, 32'hFFFF_0000, 32'd7);
        repeat (8) @(negedge clk);
        chk("restart busy before", busy, 1'b1);
        void'(exp_q.pop_back());
        do_op(0, "restart_divu_9_3", 2'b01, 32'd9, 32'd3);

        // Reset mid-CALC
        launch(0, 2'b01, 32'hFFFF_0000, 32'd7);
        repeat (13) @(negedge clk);
        start = 1'b0;
        #1;
        chk("async_reset busy", busy, 1'b0);
        chk("async_reset valid", div_valid, 1'b0);
        chk("async_reset result", divresult, 32'h0);
        @(negedge clk);
        start = 1'b1;
        do_op(0, "post_reset_divu_8_2", 2'b01, 32'd8, 32'd2);

        chk("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
